shift_reg_univ: RTL and testbench

Parametrised universal shift register for the memory-structures library, generalising the single D flip-flop (clock, active-low async reset, data, enable) to a WIDTH-bit register. Supports hold, parallel load, logical/arithmetic shifts, rotates and clear, all in single-step form. Also provides a multi-cycle burst mode that shifts a programmed number of positions with a busy/done handshake. Intended as the storage element under serial converters and small datapath sequencers.

---
 rtl/shift_reg_univ_if.sv | 30 +++
 rtl/shift_reg_univ.sv | 135 +++++++++++++
 tb/tb_shift_reg_univ.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_univ_if.sv
// Control, data and status bundle of the universal shift register.
// The sequencer side drives operations; the register side returns contents and burst status.
interface shift_reg_univ_if #(
    parameter int WIDTH = 8
);
    localparam int AMT_W = $clog2(WIDTH) + 1;

    logic             en;
    logic [2:0]       mode;
    logic             start;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, start, amt, d, sin_r, sin_l,
        input  q, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, mode, start, amt, d, sin_r, sin_l,
        output q, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/shift_reg_univ.sv
// WIDTH-bit universal shift register: single-step hold/load/shift/rotate/clear,
// plus a multi-cycle burst that repeats one shift-class mode amt times with busy/done.
module shift_reg_univ #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            Re,
    shift_reg_univ_if.slave bus
);
    localparam int AMT_W = $clog2(WIDTH) + 1;
    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_ASR  = 3'b110,
        M_CLR  = 3'b111
    } mode_t;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t           state, state_n;
    mode_t            op_r, op_n;
    logic [WIDTH-1:0] q_r, q_n;
    logic [AMT_W-1:0] cnt, cnt_n;
    logic             done_r, done_n;
    mode_t            live_mode;

    assign live_mode = mode_t'(bus.mode);

    function automatic logic [WIDTH-1:0] apply_op(
        input mode_t            op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             sr,
        input logic             sl
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (op)
            M_HOLD: r = cur;
            M_LOAD: r = ld;
            M_SHL:  r = {cur[WIDTH-2:0], sr};
            M_SHR:  r = {sl, cur[WIDTH-1:1]};
            M_ROL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:  r = {cur[0], cur[WIDTH-1:1]};
            M_ASR:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_CLR:  r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    function automatic logic is_shift(input mode_t op);
        return (op == M_SHL) || (op == M_SHR) || (op == M_ROL) ||
               (op == M_ROR) || (op == M_ASR);
    endfunction

    // NOTE: every output of this block is given a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        op_n    = op_r;
        q_n     = q_r;
        cnt_n   = cnt;
        // done is a one-cycle pulse and falls even while en is low.
        done_n  = 1'b0;

        if (bus.en) begin
            case (state)
                S_IDLE: begin
                    if (bus.start && is_shift(live_mode)) begin
                        if (bus.amt == '0) begin
                            done_n = 1'b1;
                        end else begin
                            q_n = apply_op(live_mode, q_r, bus.d, bus.sin_r, bus.sin_l);
                            if (bus.amt == CNT_ONE) begin
                                done_n = 1'b1;
                            end else begin
                                op_n    = live_mode;
                                cnt_n   = bus.amt - CNT_ONE;
                                state_n = S_BUSY;
                            end
                        end
                    end else begin
                        q_n = apply_op(live_mode, q_r, bus.d, bus.sin_r, bus.sin_l);
                    end
                end
                S_BUSY: begin
                    // Latched mode drives the burst; live mode, d and start are ignored.
                    q_n   = apply_op(op_r, q_r, bus.d, bus.sin_r, bus.sin_l);
                    cnt_n = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // NOTE: the reset is asynchronous and active-low, so it sits in the sensitivity list
    // and clears every register, aborting a burst without a done pulse.
    always_ff @(posedge clk or negedge Re) begin
        if (!Re) begin
            state  <= S_IDLE;
            op_r   <= M_HOLD;
            q_r    <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignment so all registers
            // see pre-edge values regardless of statement order.
            state  <= state_n;
            op_r   <= op_n;
            q_r    <= q_n;
            cnt    <= cnt_n;
            done_r <= done_n;
        end
    end

    assign bus.q      = q_r;
    assign bus.sout_l = q_r[WIDTH-1];
    assign bus.sout_r = q_r[0];
    assign bus.busy   = (state == S_BUSY);
    assign bus.done   = done_r;
endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8): expected outputs are queued as each
// step is driven and popped for comparison one time unit after the sampling edge.
module tb_shift_reg_univ;
    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                           ROL  = 3'b100, ROR  = 3'b101, ASR = 3'b110, CLR = 3'b111;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk;
    logic Re;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    shift_reg_univ_if #(.WIDTH(8)) bus ();

    shift_reg_univ #(.WIDTH(8)) dut (
        .clk (clk),
        .Re  (Re),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic expect_out(input string tag, input logic [7:0] q, input logic busy,
                              input logic done);
        exp_t e;
        e.tag  = tag;
        e.q    = q;
        e.busy = busy;
        e.done = done;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL scoreboard: got empty queue, expected an entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors += 4;
            assert (bus.q === e.q) else begin
                miscompares++;
                $error("FAIL %s q: got %h expected %h", e.tag, bus.q, e.q);
            end
            assert (bus.busy === e.busy) else begin
                miscompares++;
                $error("FAIL %s busy: got %b expected %b", e.tag, bus.busy, e.busy);
            end
            assert (bus.done === e.done) else begin
                miscompares++;
                $error("FAIL %s done: got %b expected %b", e.tag, bus.done, e.done);
            end
            assert ({bus.sout_l, bus.sout_r} === {e.q[7], e.q[0]}) else begin
                miscompares++;
                $error("FAIL %s sout: got %b%b expected %b%b", e.tag, bus.sout_l,
                       bus.sout_r, e.q[7], e.q[0]);
            end
        end
    endtask

    task automatic drive(input logic [2:0] m, input logic s, input logic [3:0] a,
                         input logic [7:0] dv, input logic sr, input logic sl);
        bus.mode  = m;
        bus.start = s;
        bus.amt   = a;
        bus.d     = dv;
        bus.sin_r = sr;
        bus.sin_l = sl;
    endtask

    // One clock: queue the expectation, let the edge happen, compare 1 unit later.
    task automatic step(input string tag, input logic [7:0] q, input logic busy,
                        input logic done);
        expect_out(tag, q, busy, done);
        @(posedge clk);
        #1;
        check();
    endtask

    // Asynchronous reset pulse between edges, checked before any edge follows.
    task automatic async_reset(input string tag);
        Re = 1'b0;
        #2;
        expect_out(tag, 8'h00, 1'b0, 1'b0);
        check();
        #1;
        Re = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        vectors     = 0;
        miscompares = 0;

        Re     = 1'b0;
        bus.en = 1'b1;
        drive(LOAD, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
        #2;
        expect_out("por", 8'h00, 1'b0, 1'b0);
        check();
        step("por_edge", 8'h00, 1'b0, 1'b0);
        Re = 1'b1;

        drive(LOAD, 1'b0, 4'd0, 8'h5A, 1'b0, 1'b0);
        step("load_5a", 8'h5A, 1'b0, 1'b0);
        async_reset("rst_between_edges");
        drive(HOLD, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
        step("hold_after_rst", 8'h00, 1'b0, 1'b0);

        // Single-step operations
        drive(LOAD, 1'b0, 4'd0, 8'hB4, 1'b0, 1'b0);
        step("load_b4", 8'hB4, 1'b0, 1'b0);
        drive(SHL, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        step("shl", 8'h69, 1'b0, 1'b0);
        drive(SHR, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        step("shr", 8'h34, 1'b0, 1'b0);
        drive(LOAD, 1'b0, 4'd0, 8'h80, 1'b0, 1'b0);
        step("load_80", 8'h80, 1'b0, 1'b0);
        drive(ASR, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        step("asr", 8'hC0, 1'b0, 1'b0);
        drive(LOAD, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0);
        step("load_01", 8'h01, 1'b0, 1'b0);
        drive(ROR, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        step("ror", 8'h80, 1'b0, 1'b0);
        drive(ROL, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        step("rol", 8'h01, 1'b0, 1'b0);
        drive(CLR, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
        step("clr", 8'h00, 1'b0, 1'b0);
        drive(LOAD, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0);
        step("load_3c", 8'h3C, 1'b0, 1'b0);
        drive(HOLD, 1'b0, 4'd0, 8'hFF, 1'b1, 1'b1);
        step("hold", 8'h3C, 1'b0, 1'b0);
        bus.en = 1'b0;
        drive(LOAD, 1'b1, 4'd3, 8'hFF, 1'b0, 1'b0);
        step("en_low_freeze", 8'h3C, 1'b0, 1'b0);
        bus.en = 1'b1;
        drive(LOAD, 1'b1, 4'd3, 8'h96, 1'b0, 1'b0);
        step("start_load", 8'h96, 1'b0, 1'b0);
        drive(HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        step("start_load_nodone", 8'h96, 1'b0, 1'b0);

        // Burst ROL by 3 with a start attempt while busy
        drive(LOAD, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0);
        step("load_81", 8'h81, 1'b0, 1'b0);
        drive(ROL, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
        step("burst_e0", 8'h03, 1'b1, 1'b0);
        drive(CLR, 1'b1, 4'd5, 8'hFF, 1'b0, 1'b0);
        step("burst_e1", 8'h06, 1'b1, 1'b0);
        step("burst_e2", 8'h0C, 1'b0, 1'b1);
        drive(HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        step("burst_done_fall", 8'h0C, 1'b0, 1'b0);

        // Same burst stalled for two cycles
        drive(LOAD, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0);
        step("load_81b", 8'h81, 1'b0, 1'b0);
        drive(ROL, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
        step("stall_e0", 8'h03, 1'b1, 1'b0);
        drive(HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        bus.en = 1'b0;
        step("stall_s1", 8'h03, 1'b1, 1'b0);
        step("stall_s2", 8'h03, 1'b1, 1'b0);
        bus.en = 1'b1;
        step("stall_e1", 8'h06, 1'b1, 1'b0);
        step("stall_e2", 8'h0C, 1'b0, 1'b1);
        step("stall_done_fall", 8'h0C, 1'b0, 1'b0);

        // amt=0 and amt=1 bursts, done falling with en low, start during done
        drive(SHL, 1'b1, 4'd0, 8'h00, 1'b1, 1'b0);
        step("amt0", 8'h0C, 1'b0, 1'b1);
        drive(HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        step("amt0_fall", 8'h0C, 1'b0, 1'b0);
        drive(SHR, 1'b1, 4'd1, 8'h00, 1'b0, 1'b1);
        step("amt1_shr", 8'h86, 1'b0, 1'b1);
        drive(SHL, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0);
        step("amt1_shl", 8'h0C, 1'b0, 1'b1);
        bus.en = 1'b0;
        step("done_fall_en_low", 8'h0C, 1'b0, 1'b0);
        bus.en = 1'b1;
        drive(ROR, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0);
        step("amt1_ror", 8'h06, 1'b0, 1'b1);
        drive(ROR, 1'b1, 4'd2, 8'h00, 1'b0, 1'b0);
        step("start_in_done", 8'h03, 1'b1, 1'b0);
        drive(HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        step("start_in_done_e1", 8'h81, 1'b0, 1'b1);
        step("start_in_done_fall", 8'h81, 1'b0, 1'b0);

        // Reset mid-burst
        drive(LOAD, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
        step("load_ff", 8'hFF, 1'b0, 1'b0);
        drive(SHR, 1'b1, 4'd6, 8'h00, 1'b0, 1'b0);
        step("mid_e0", 8'h7F, 1'b1, 1'b0);
        drive(HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        step("mid_e1", 8'h3F, 1'b1, 1'b0);
        async_reset("mid_rst");
        step("mid_post1", 8'h00, 1'b0, 1'b0);
        step("mid_post2", 8'h00, 1'b0, 1'b0);
        drive(LOAD, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
        step("mid_load", 8'hA5, 1'b0, 1'b0);

        // Wrap: ROL by WIDTH returns the original value
        drive(LOAD, 1'b0, 4'd0, 8'h5A, 1'b0, 1'b0);
        step("load_5a_w", 8'h5A, 1'b0, 1'b0);
        drive(ROL, 1'b1, 4'd8, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            v = (8'h5A << i) | (8'h5A >> (8 - i));
            step("rol8_mid", v, 1'b1, 1'b0);
            drive(HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        end
        step("rol8_end", 8'h5A, 1'b0, 1'b1);

        // SHL by 9 with ones shifted in
        drive(SHL, 1'b1, 4'd9, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i < 9; i++) begin
            v = (i >= 8) ? 8'hFF : ((8'h5A << i) | 8'((1 << i) - 1));
            step("shl9_mid", v, 1'b1, 1'b0);
            drive(HOLD, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        end
        step("shl9_end", 8'hFF, 1'b0, 1'b1);
        step("shl9_fall", 8'hFF, 1'b0, 1'b0);

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
